// File: rtl/muldiv_unit.sv
// Iterative multicycle MULT/MULTU/DIV/DIVU unit for the EX stage.
// Operates on magnitudes for WIDTH cycles, then applies the sign fix and writes HI/LO.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             hiwrite,
    output logic             lowrite
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t             state;
    logic [CW-1:0]      counter;
    logic [1:0]         op_r;
    logic [WIDTH-1:0]   a_raw;
    logic               a_neg;
    logic               b_neg;
    logic               divzero;
    logic [WIDTH-1:0]   opnd;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   rem;

    logic               in_signed;
    logic [WIDTH-1:0]   in_a_mag;
    logic [WIDTH-1:0]   in_b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_diff;
    logic               div_ge;
    logic               is_div;
    logic               is_signed;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo_s;
    logic [WIDTH-1:0]   rem_s;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    assign hiwrite = done;
    assign lowrite = done;

    always_comb begin
        in_signed = ~op[0];
        in_a_mag  = (in_signed && src_a[WIDTH-1]) ? -src_a : src_a;
        in_b_mag  = (in_signed && src_b[WIDTH-1]) ? -src_b : src_b;

        // Shift-add: acc[0] is the current multiplier bit; the carry lands in bit WIDTH.
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);

        // Restoring division: rem:acc[WIDTH-1:0] shifts left, dividend bits feed rem.
        div_shift = {rem, acc[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opnd});
        div_diff  = div_shift[WIDTH-1:0] - opnd;

        is_div    = op_r[1];
        is_signed = ~op_r[0];
        prod_s    = (is_signed && (a_neg ^ b_neg)) ? -acc : acc;
        quo_s     = (is_signed && (a_neg ^ b_neg)) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_s     = (is_signed && a_neg) ? -rem : rem;

        if (divzero) begin
            fix_hi = a_raw;
            fix_lo = '1;
        end else if (is_div) begin
            fix_hi = rem_s;
            fix_lo = quo_s;
        end else begin
            fix_hi = prod_s[2*WIDTH-1:WIDTH];
            fix_lo = prod_s[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            counter <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            hi_out  <= '0;
            lo_out  <= '0;
            op_r    <= '0;
            a_raw   <= '0;
            a_neg   <= 1'b0;
            b_neg   <= 1'b0;
            divzero <= 1'b0;
            opnd    <= '0;
            acc     <= '0;
            rem     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !cancel) begin
                        state   <= CALC;
                        busy    <= 1'b1;
                        counter <= '0;
                        op_r    <= op;
                        a_raw   <= src_a;
                        a_neg   <= in_signed & src_a[WIDTH-1];
                        b_neg   <= in_signed & src_b[WIDTH-1];
                        divzero <= op[1] && (src_b == '0);
                        rem     <= '0;
                        if (op[1]) begin
                            opnd <= in_b_mag;
                            acc  <= {{WIDTH{1'b0}}, in_a_mag};
                        end else begin
                            opnd <= in_a_mag;
                            acc  <= {{WIDTH{1'b0}}, in_b_mag};
                        end
                    end
                end
                CALC: begin
                    if (cancel) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        if (is_div) begin
                            rem              <= div_ge ? div_diff : div_shift[WIDTH-1:0];
                            acc[WIDTH-1:0]   <= {acc[WIDTH-2:0], div_ge};
                        end else begin
                            acc <= {mul_sum, acc[WIDTH-1:1]};
                        end
                        counter <= counter + CW'(1);
                        if (counter == LAST) begin
                            state <= FIX;
                        end
                    end
                end
                FIX: begin
                    if (cancel) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        hi_out <= fix_hi;
                        lo_out <= fix_lo;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (WIDTH=32).
module tb_muldiv_unit;

    localparam int unsigned W = 32;

    logic         clk    = 1'b0;
    logic         reset  = 1'b0;
    logic         start  = 1'b0;
    logic         cancel = 1'b0;
    logic [1:0]   op     = '0;
    logic [W-1:0] src_a  = '0;
    logic [W-1:0] src_b  = '0;
    logic         busy;
    logic         done;
    logic         hiwrite;
    logic         lowrite;
    logic [W-1:0] hi_out;
    logic [W-1:0] lo_out;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int done_cyc = 0;
    logic [W-1:0] exp_hi = '0;
    logic [W-1:0] exp_lo = '0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .src_a   (src_a),
        .src_b   (src_b),
        .cancel  (cancel),
        .busy    (busy),
        .done    (done),
        .hi_out  (hi_out),
        .lo_out  (lo_out),
        .hiwrite (hiwrite),
        .lowrite (lowrite)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Presents one start cycle; on return the op has been accepted (E0) and inputs are scrambled.
    task automatic launch(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        @(posedge clk); #1;
        start = 1'b0;
        op    = 2'($urandom);
        src_a = $urandom;
        src_b = $urandom;
    endtask

    // inj >= 0 re-asserts start with different operands at that CALC cycle.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] ehi,
                          input logic [W-1:0] elo, input int inj);
        int n;
        launch(o, a, b);
        n = 0;
        while (!done && n < 100) begin
            if (n == inj) begin
                start = 1'b1;
                op    = ~o;
                src_a = 32'h0000_0005;
                src_b = 32'h0000_0003;
            end
            @(posedge clk); #1;
            start = 1'b0;
            n++;
            if (n == inj + 1) check({tag, "_busy"}, 64'(busy), 64'h1);
        end
        check({tag, "_lat"}, 64'(n), 64'd33);
        check({tag, "_hi"}, 64'(hi_out), 64'(ehi));
        check({tag, "_lo"}, 64'(lo_out), 64'(elo));
        check({tag, "_wr"}, 64'({hiwrite, lowrite}), 64'h3);
        done_cyc = cyc;
        @(posedge clk); #1;
        check({tag, "_pulse"}, 64'({done, hiwrite, lowrite, busy}), 64'h0);
        exp_hi = ehi;
        exp_lo = elo;
    endtask

    task automatic watch_quiet(input string tag);
        int strobes;
        strobes = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done || hiwrite || lowrite) strobes++;
        end
        check({tag, "_nostrobe"}, 64'(strobes), 64'h0);
        check({tag, "_hold"}, {hi_out, lo_out}, {exp_hi, exp_lo});
    endtask

    task automatic cancel_at(input string tag, input int k);
        launch(2'b00, 32'h0000_0009, 32'h0000_0009);
        repeat (k) begin
            @(posedge clk); #1;
        end
        cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        check({tag, "_busy"}, 64'(busy), 64'h0);
        watch_quiet(tag);
    endtask

    initial begin
        int d1;
        #12;
        check("rst_ctl", 64'({busy, done, hiwrite, lowrite}), 64'h0);
        check("rst_hilo", {hi_out, lo_out}, 64'h0);
        reset = 1'b1;
        @(posedge clk); #1;

        run_op("multu_max",  2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, -1);
        run_op("mult_neg",   2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, -1);
        run_op("mult_min",   2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, -1);
        run_op("mult_m1m1",  2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, -1);
        run_op("multu_carry",2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, -1);
        run_op("div_n7_2",   2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, -1);
        run_op("div_7_n2",   2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, -1);
        run_op("div_n7_n2",  2'b10, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003, -1);
        run_op("divu_100_7", 2'b11, 32'd100,       32'd7,         32'd2,         32'd14,        -1);
        run_op("divu_dz",    2'b11, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF, -1);
        run_op("div_dz",     2'b10, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF, -1);
        run_op("div_dz_neg", 2'b10, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        run_op("div_ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, -1);

        run_op("ign_start",  2'b01, 32'h0000_1234, 32'h0000_0010, 32'h0000_0000, 32'h0001_2340, 5);
        d1 = done_cyc;
        run_op("b2b",        2'b01, 32'h0000_0003, 32'h0000_0005, 32'h0000_0000, 32'h0000_000F, -1);
        // Cycles strictly between the two done pulses: IDLE, then 33 edges to the next DONE.
        check("b2b_gap", 64'(done_cyc - d1 - 1), 64'd34);

        cancel_at("cancel_calc", 10);
        cancel_at("cancel_fix", 32);

        start  = 1'b1;
        cancel = 1'b1;
        op     = 2'b01;
        @(posedge clk); #1;
        start  = 1'b0;
        cancel = 1'b0;
        check("cancel_idle", 64'(busy), 64'h0);

        launch(2'b01, 32'h0000_0006, 32'h0000_0007);
        repeat (33) begin
            @(posedge clk); #1;
        end
        check("cancel_done_strobe", 64'({done, hiwrite, lowrite}), 64'h7);
        cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        check("cancel_done_val", {hi_out, lo_out}, 64'd42);
        exp_hi = 32'd0;
        exp_lo = 32'd42;

        launch(2'b01, 32'h0000_FFFF, 32'h0000_FFFF);
        repeat (8) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check("arst_ctl", 64'({busy, done, hiwrite, lowrite}), 64'h0);
        check("arst_hilo", {hi_out, lo_out}, 64'h0);
        #3 reset = 1'b1;
        exp_hi = '0;
        exp_lo = '0;
        watch_quiet("arst");

        run_op("post_rst",   2'b11, 32'd100,       32'd7,         32'd2,         32'd14,        -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
